// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared types and default parameters for the Viterbi BER checker.
//   ber_state_t : checker FSM state (SEARCH while hunting for the decoder
//                 latency, LOCKED while scoring bits)
//   DEF_*       : default values for the checker parameters
package viterbi_pkg;

    typedef enum logic {SEARCH, LOCKED} ber_state_t;

    localparam int DEF_DEPTH   = 64;
    localparam int DEF_WIN     = 32;
    localparam int DEF_ERR_TH  = 2;
    localparam int DEF_LOSS_TH = 8;
    localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/viterbi_ber_checker_sat_counter.sv
// sat_counter
// Saturating up-counter with a sticky "reached all-ones" flag.
// Ports:
//   clk    in  1  clock
//   rst    in  1  asynchronous active-low reset
//   inc    in  1  count enable (ignored once the count is all-ones)
//   clr    in  1  synchronous clear of count and flag (wins over inc)
//   cnt    out W  current count
//   at_max out 1  set on the edge the count becomes all-ones
module sat_counter
    import viterbi_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [W-1:0] NEAR_MAX = ALL_ONES - W'(1);

    logic [W-1:0] cnt_reg;
    logic         at_max_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            at_max_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg    <= '0;
            at_max_reg <= 1'b0;
        end else if (inc && (cnt_reg != ALL_ONES)) begin
            cnt_reg <= cnt_reg + W'(1);
            if (cnt_reg == NEAR_MAX) begin
                at_max_reg <= 1'b1;
            end
        end
    end

    assign cnt    = cnt_reg;
    assign at_max = at_max_reg;

endmodule

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
// Finds the decoder latency by comparing decoded bits against a history of
// the encoder input, then counts bits and bit errors while locked.
// Ports:
//   clk          in  1       clock
//   rst          in  1       asynchronous active-low reset
//   ref_valid_i  in  1       ref_bit_i valid, shifted into the history
//   ref_bit_i    in  1       original encoder input bit
//   dec_valid_i  in  1       dec_bit_i valid, one compare is made
//   dec_bit_i    in  1       decoder output bit
//   clear_i      in  1       synchronous clear of counters and FSM
//   locked_o     out 1       latency found, counting active
//   latency_o    out LAT_W   locked latency
//   bit_ct_o     out CNT_W   compares made while locked
//   err_ct_o     out CNT_W   mismatches seen while locked
//   err_pulse_o  out 1       one-cycle pulse per locked mismatch
//   sat_o        out 1       sticky: a counter reached all-ones
module viterbi_ber_checker
    import viterbi_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int WIN     = DEF_WIN,
    parameter int ERR_TH  = DEF_ERR_TH,
    parameter int LOSS_TH = DEF_LOSS_TH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ref_valid_i,
    input  logic                     ref_bit_i,
    input  logic                     dec_valid_i,
    input  logic                     dec_bit_i,
    input  logic                     clear_i,
    output logic                     locked_o,
    output logic [$clog2(DEPTH)-1:0] latency_o,
    output logic [CNT_W-1:0]         bit_ct_o,
    output logic [CNT_W-1:0]         err_ct_o,
    output logic                     err_pulse_o,
    output logic                     sat_o
);

    localparam int LAT_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int WIN_W  = $clog2(WIN + 1);

    logic [DEPTH-1:0]  hist_reg;
    logic [DEPTH-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_reg;
    logic [LAT_W-1:0]  cand_reg, cand_next;
    logic [LAT_W-1:0]  lat_reg, lat_next;
    logic [WIN_W-1:0]  win_reg, win_next;
    logic [WIN_W-1:0]  mis_reg, mis_next;
    logic [WIN_W-1:0]  mis_total;
    logic              err_pulse_reg;
    ber_state_t        state_reg, state_next;

    logic counted, mismatch, win_end, win_pass, loss_hit;
    logic bit_inc, err_inc, bit_at_max, err_at_max;

    // History shift: stage 0 takes the new bit, stage gi takes stage gi-1.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_shift[gi] = ref_bit_i;
            end else begin : g_tail
                assign hist_shift[gi] = hist_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (ref_valid_i) begin
            hist_reg <= hist_shift;
            if (fill_reg != FILL_W'(DEPTH)) begin
                fill_reg <= fill_reg + FILL_W'(1);
            end
        end
    end

    // Compare uses the pre-edge history; a candidate only counts once the
    // history actually holds a bit at that depth.
    assign counted   = dec_valid_i && (fill_reg > FILL_W'(cand_reg));
    assign mismatch  = dec_bit_i ^ hist_reg[cand_reg];
    assign mis_total = mis_reg + WIN_W'(mismatch);
    assign win_end   = (win_reg == WIN_W'(WIN - 1));
    assign win_pass  = (mis_total <= WIN_W'(ERR_TH));
    assign loss_hit  = mismatch && (mis_total >= WIN_W'(LOSS_TH));

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        if (clear_i) begin
            state_next = SEARCH;
        end else if (counted) begin
            case (state_reg)
                SEARCH:  if (win_end && win_pass) state_next = LOCKED;
                LOCKED:  if (loss_hit)            state_next = SEARCH;
                default: state_next = SEARCH;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        locked_o = (state_reg == LOCKED);
    end

    // Window counters, candidate and latency
    always_comb begin
        win_next  = win_reg;
        mis_next  = mis_reg;
        cand_next = cand_reg;
        lat_next  = lat_reg;
        if (clear_i) begin
            win_next  = '0;
            mis_next  = '0;
            cand_next = '0;
        end else if (counted) begin
            if (state_reg == LOCKED && loss_hit) begin
                win_next  = '0;
                mis_next  = '0;
                cand_next = '0;
            end else if (win_end) begin
                win_next = '0;
                mis_next = '0;
                if (state_reg == SEARCH) begin
                    if (win_pass) begin
                        lat_next = cand_reg;
                    end else begin
                        cand_next = (cand_reg == LAT_W'(DEPTH - 1)) ? '0
                                                                     : cand_reg + LAT_W'(1);
                    end
                end
            end else begin
                win_next = win_reg + WIN_W'(1);
                mis_next = mis_total;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_reg       <= '0;
            mis_reg       <= '0;
            cand_reg      <= '0;
            lat_reg       <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            win_reg       <= win_next;
            mis_reg       <= mis_next;
            cand_reg      <= cand_next;
            lat_reg       <= lat_next;
            err_pulse_reg <= err_inc;
        end
    end

    // Scoring: the edge that loses lock still scores its own compare.
    assign bit_inc = counted && !clear_i && (state_reg == LOCKED);
    assign err_inc = bit_inc && mismatch;

    sat_counter #(.W(CNT_W)) u_bit_ct (
        .clk    (clk),
        .rst    (rst),
        .inc    (bit_inc),
        .clr    (clear_i),
        .cnt    (bit_ct_o),
        .at_max (bit_at_max)
    );

    sat_counter #(.W(CNT_W)) u_err_ct (
        .clk    (clk),
        .rst    (rst),
        .inc    (err_inc),
        .clr    (clear_i),
        .cnt    (err_ct_o),
        .at_max (err_at_max)
    );

    assign latency_o   = lat_reg;
    assign err_pulse_o = err_pulse_reg;
    assign sat_o       = bit_at_max | err_at_max;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker
// Directed bench: PRBS7 reference, decoder stream = reference delayed by
// five valid cycles (latency 4). A second instance with 4-bit counters
// shares the stimulus to exercise saturation.
module tb_viterbi_ber_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i;

    logic        locked_o, err_pulse_o, sat_o;
    logic [5:0]  latency_o;
    logic [31:0] bit_ct_o, err_ct_o;

    logic        s_locked, s_err_pulse, s_sat;
    logic [5:0]  s_latency;
    logic [3:0]  s_bit_ct, s_err_ct;

    viterbi_ber_checker dut (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid_i),
        .ref_bit_i   (ref_bit_i),
        .dec_valid_i (dec_valid_i),
        .dec_bit_i   (dec_bit_i),
        .clear_i     (clear_i),
        .locked_o    (locked_o),
        .latency_o   (latency_o),
        .bit_ct_o    (bit_ct_o),
        .err_ct_o    (err_ct_o),
        .err_pulse_o (err_pulse_o),
        .sat_o       (sat_o)
    );

    viterbi_ber_checker #(.CNT_W(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid_i),
        .ref_bit_i   (ref_bit_i),
        .dec_valid_i (dec_valid_i),
        .dec_bit_i   (dec_bit_i),
        .clear_i     (clear_i),
        .locked_o    (s_locked),
        .latency_o   (s_latency),
        .bit_ct_o    (s_bit_ct),
        .err_ct_o    (s_err_ct),
        .err_pulse_o (s_err_pulse),
        .sat_o       (s_sat)
    );

    logic ref_mem [0:2047];
    int   t;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit past it.
    // t is the index of the next reference bit / valid edge.
    task automatic step(input bit vld, input bit flip, input bit clr);
        ref_valid_i = vld;
        dec_valid_i = vld;
        ref_bit_i   = ref_mem[t];
        dec_bit_i   = ((t >= 5) ? ref_mem[t-5] : 1'b0) ^ flip;
        clear_i     = clr;
        @(posedge clk);
        #1;
        if (vld) t++;
    endtask

    // Clean steps until edge 'last' has been processed.
    task automatic run_to(input int last);
        while (t <= last) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] s;
        logic       b;
        bit         flip;
        int         e;

        s = 7'h7F;
        for (int i = 0; i < 2048; i++) begin
            b = s[6] ^ s[5];
            ref_mem[i] = b;
            s = {s[5:0], b};
        end

        ref_valid_i = 1'b0; dec_valid_i = 1'b0;
        ref_bit_i = 1'b0; dec_bit_i = 1'b0; clear_i = 1'b0;
        t = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked",  32'(locked_o),    0);
        chk("rst_latency", 32'(latency_o),   0);
        chk("rst_bit_ct",  bit_ct_o,         0);
        chk("rst_err_ct",  err_ct_o,         0);
        chk("rst_pulse",   32'(err_pulse_o), 0);
        chk("rst_sat",     32'(sat_o),       0);
        rst = 1'b1;
        $display("[tb] reset released");

        // Clean lock with a 3-cycle stall of both streams mid-search
        run_to(99);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        run_to(159);
        chk("lock_early", 32'(locked_o), 0);
        run_to(160);
        chk("lock_rise",    32'(locked_o),  1);
        chk("lock_latency", 32'(latency_o), 4);
        chk("lock_bit_ct",  bit_ct_o,       0);
        chk("lock_err_ct",  err_ct_o,       0);
        chk("sat_lock",     32'(s_locked),  1);
        $display("[tb] clean lock: locked=%0d latency=%0d", locked_o, latency_o);

        // Tolerated errors: flip every 16th decoded bit for 8 windows
        for (e = 161; e <= 416; e++) begin
            flip = (e >= 176) && (((e - 176) % 16) == 0);
            step(1'b1, flip, 1'b0);
            chk("tol_pulse",  32'(err_pulse_o), 32'(flip));
            chk("tol_bit_ct", bit_ct_o,         32'(e - 160));
            if (((e - 160) % 32) == 0) chk("tol_err_ct", err_ct_o, 32'((e - 160) / 16));
            if (e == 174) chk("sat_flag_early", 32'(s_sat), 0);
            if (e == 175) begin
                chk("sat_flag_set", 32'(s_sat),    1);
                chk("sat_bit_at15", 32'(s_bit_ct), 15);
            end
        end
        chk("tol_locked",   32'(locked_o), 1);
        chk("sat_err_stop", 32'(s_err_ct), 15);
        chk("sat_bit_stop", 32'(s_bit_ct), 15);
        chk("sat_flag",     32'(s_sat),    1);
        $display("[tb] tolerated errors: bit_ct=%0d err_ct=%0d sat_err=%0d", bit_ct_o, err_ct_o, s_err_ct);

        // Loss of lock: 8 consecutive flips at the start of a window
        for (e = 417; e <= 424; e++) begin
            step(1'b1, 1'b1, 1'b0);
            if (e == 423) chk("loss_hold", 32'(locked_o), 1);
        end
        chk("loss_fall",    32'(locked_o),    0);
        chk("loss_pulse",   32'(err_pulse_o), 1);
        chk("loss_err_ct",  err_ct_o,         24);
        chk("loss_bit_ct",  bit_ct_o,         264);
        chk("loss_latency", 32'(latency_o),   4);
        $display("[tb] loss of lock at t=424 err_ct=%0d", err_ct_o);

        // Relock after restarting from candidate 0
        run_to(583);
        chk("relock_early", 32'(locked_o), 0);
        run_to(584);
        chk("relock_rise",    32'(locked_o),  1);
        chk("relock_latency", 32'(latency_o), 4);
        chk("relock_err_ct",  err_ct_o,       24);
        chk("relock_bit_ct",  bit_ct_o,       264);
        run_to(600);
        chk("relock_count", bit_ct_o, 280);
        $display("[tb] relock: latency=%0d bit_ct=%0d", latency_o, bit_ct_o);

        // Clear while locked (streams keep running)
        step(1'b1, 1'b0, 1'b1);
        chk("clr_locked", 32'(locked_o), 0);
        chk("clr_bit_ct", bit_ct_o,      0);
        chk("clr_err_ct", err_ct_o,      0);
        chk("clr_sat",    32'(s_sat),    0);
        chk("clr_s_err",  32'(s_err_ct), 0);
        run_to(760);
        chk("clr_relock_early", 32'(locked_o), 0);
        run_to(761);
        chk("clr_relock",   32'(locked_o),  1);
        chk("clr_latency",  32'(latency_o), 4);
        chk("clr_bit_zero", bit_ct_o,       0);
        $display("[tb] clear and relock at t=761");

        // Asynchronous reset mid-window
        run_to(770);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_locked",  32'(locked_o),    0);
        chk("arst_latency", 32'(latency_o),   0);
        chk("arst_bit_ct",  bit_ct_o,         0);
        chk("arst_err_ct",  err_ct_o,         0);
        chk("arst_pulse",   32'(err_pulse_o), 0);
        chk("arst_sat",     32'(s_sat),       0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        // History refills from scratch: first counted compare is one edge in
        run_to(930);
        chk("arst_relock_early", 32'(locked_o), 0);
        run_to(931);
        chk("arst_relock",   32'(locked_o),  1);
        chk("arst_latency4", 32'(latency_o), 4);
        $display("[tb] async reset and relock at t=931");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
